// File: rtl/instruction_decoder_pkg.sv
// Shared ISA definitions for the compute core: opcodes, scheduler states and
// the encodings of the decoder's mux and function-select outputs.
package instruction_decoder_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'b0000,
      OP_BRNZP = 4'b0001,
      OP_CMP   = 4'b0010,
      OP_ADD   = 4'b0011,
      OP_SUB   = 4'b0100,
      OP_MUL   = 4'b0101,
      OP_DIV   = 4'b0110,
      OP_LDR   = 4'b0111,
      OP_STR   = 4'b1000,
      OP_CONST = 4'b1001,
      OP_FMA   = 4'b1010,
      OP_ACT   = 4'b1011,
      OP_RES_C = 4'b1100,
      OP_RES_D = 4'b1101,
      OP_RES_E = 4'b1110,
      OP_RET   = 4'b1111
   } opcode_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_REQUEST = 3'd3,
      ST_WAIT    = 3'd4,
      ST_EXECUTE = 3'd5,
      ST_UPDATE  = 3'd6,
      ST_DONE    = 3'd7
   } core_state_t;

   // Register-file write source select.
   localparam logic [2:0] RIN_ALU   = 3'd0;
   localparam logic [2:0] RIN_MEM   = 3'd1;
   localparam logic [2:0] RIN_IMM   = 3'd2;
   localparam logic [2:0] RIN_FMA   = 3'd3;
   localparam logic [2:0] RIN_ACT   = 3'd4;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_MUL   = 2'd2;
   localparam logic [1:0] ALU_DIV   = 2'd3;

   localparam logic [1:0] ACT_RELU  = 2'd0;
   localparam logic [1:0] ACT_LRELU = 2'd1;
   localparam logic [1:0] ACT_SIGM  = 2'd2;
   localparam logic [1:0] ACT_TANH  = 2'd3;

endpackage

// File: rtl/instruction_decoder.sv
// Per-core instruction decoder: captures fields and control strobes on the
// DECODE edge and holds them for the remainder of the instruction.
module instruction_decoder
   import instruction_decoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  core_state,
   input  logic [15:0] instruction,
   output logic [3:0]  decoded_rd_address,
   output logic [3:0]  decoded_rs_address,
   output logic [3:0]  decoded_rt_address,
   output logic [2:0]  decoded_nzp,
   output logic [7:0]  decoded_immediate,
   output logic        decoded_reg_write_enable,
   output logic        decoded_mem_read_enable,
   output logic        decoded_mem_write_enable,
   output logic        decoded_nzp_write_enable,
   output logic [2:0]  decoded_reg_input_mux,
   output logic [1:0]  decoded_alu_arithmetic_mux,
   output logic        decoded_alu_output_mux,
   output logic        decoded_pc_mux,
   output logic        decoded_fma_enable,
   output logic        decoded_act_enable,
   output logic [1:0]  decoded_act_func,
   output logic        decoded_ret
);

   opcode_t opcode;
   assign opcode = opcode_t'(instruction[15:12]);

   always_ff @(posedge clk) begin
      if (reset) begin
         decoded_rd_address         <= '0;
         decoded_rs_address         <= '0;
         decoded_rt_address         <= '0;
         decoded_nzp                <= '0;
         decoded_immediate          <= '0;
         decoded_reg_write_enable   <= 1'b0;
         decoded_mem_read_enable    <= 1'b0;
         decoded_mem_write_enable   <= 1'b0;
         decoded_nzp_write_enable   <= 1'b0;
         decoded_reg_input_mux      <= RIN_ALU;
         decoded_alu_arithmetic_mux <= ALU_ADD;
         decoded_alu_output_mux     <= 1'b0;
         decoded_pc_mux             <= 1'b0;
         decoded_fma_enable         <= 1'b0;
         decoded_act_enable         <= 1'b0;
         decoded_act_func           <= ACT_RELU;
         decoded_ret                <= 1'b0;
      end else if (core_state == ST_DECODE) begin
         decoded_rd_address <= instruction[11:8];
         decoded_rs_address <= instruction[7:4];
         decoded_rt_address <= instruction[3:0];
         decoded_nzp        <= instruction[11:9];
         decoded_immediate  <= instruction[7:0];

         // Clear every control first so nothing leaks from the previous op.
         decoded_reg_write_enable   <= 1'b0;
         decoded_mem_read_enable    <= 1'b0;
         decoded_mem_write_enable   <= 1'b0;
         decoded_nzp_write_enable   <= 1'b0;
         decoded_reg_input_mux      <= RIN_ALU;
         decoded_alu_arithmetic_mux <= ALU_ADD;
         decoded_alu_output_mux     <= 1'b0;
         decoded_pc_mux             <= 1'b0;
         decoded_fma_enable         <= 1'b0;
         decoded_act_enable         <= 1'b0;
         decoded_act_func           <= ACT_RELU;
         decoded_ret                <= 1'b0;

         case (opcode)
            OP_BRNZP: decoded_pc_mux <= 1'b1;
            OP_CMP: begin
               decoded_alu_output_mux   <= 1'b1;
               decoded_nzp_write_enable <= 1'b1;
            end
            OP_ADD: begin
               decoded_reg_write_enable   <= 1'b1;
               decoded_alu_arithmetic_mux <= ALU_ADD;
            end
            OP_SUB: begin
               decoded_reg_write_enable   <= 1'b1;
               decoded_alu_arithmetic_mux <= ALU_SUB;
            end
            OP_MUL: begin
               decoded_reg_write_enable   <= 1'b1;
               decoded_alu_arithmetic_mux <= ALU_MUL;
            end
            OP_DIV: begin
               decoded_reg_write_enable   <= 1'b1;
               decoded_alu_arithmetic_mux <= ALU_DIV;
            end
            OP_LDR: begin
               decoded_reg_write_enable <= 1'b1;
               decoded_reg_input_mux    <= RIN_MEM;
               decoded_mem_read_enable  <= 1'b1;
            end
            OP_STR: decoded_mem_write_enable <= 1'b1;
            OP_CONST: begin
               decoded_reg_write_enable <= 1'b1;
               decoded_reg_input_mux    <= RIN_IMM;
            end
            OP_FMA: begin
               decoded_reg_write_enable <= 1'b1;
               decoded_reg_input_mux    <= RIN_FMA;
               decoded_fma_enable       <= 1'b1;
            end
            OP_ACT: begin
               decoded_reg_write_enable <= 1'b1;
               decoded_reg_input_mux    <= RIN_ACT;
               decoded_act_enable       <= 1'b1;
               decoded_act_func         <= instruction[1:0];
            end
            OP_RET: decoded_ret <= 1'b1;
            default: ;  // NOP and reserved opcodes leave all controls at 0
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: each step drives one edge and
// checks the full output vector against hand-computed values.
module tb_instruction_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  core_state;
   logic [15:0] instruction;
   logic [3:0]  rd, rs, rt;
   logic [2:0]  nzp;
   logic [7:0]  imm;
   logic        rw, mr, mw, nw;
   logic [2:0]  rim;
   logic [1:0]  aam;
   logic        aom, pcm, fma, act;
   logic [1:0]  af;
   logic        ret;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instruction_decoder dut (
      .clk                        (clk),
      .reset                      (reset),
      .core_state                 (core_state),
      .instruction                (instruction),
      .decoded_rd_address         (rd),
      .decoded_rs_address         (rs),
      .decoded_rt_address         (rt),
      .decoded_nzp                (nzp),
      .decoded_immediate          (imm),
      .decoded_reg_write_enable   (rw),
      .decoded_mem_read_enable    (mr),
      .decoded_mem_write_enable   (mw),
      .decoded_nzp_write_enable   (nw),
      .decoded_reg_input_mux      (rim),
      .decoded_alu_arithmetic_mux (aam),
      .decoded_alu_output_mux     (aom),
      .decoded_pc_mux             (pcm),
      .decoded_fma_enable         (fma),
      .decoded_act_enable         (act),
      .decoded_act_func           (af),
      .decoded_ret                (ret)
   );

   // Observed outputs packed in a fixed order for whole-vector comparison.
   logic [38:0] obs;
   assign obs = {rd, rs, rt, nzp, imm, rw, mr, mw, nw, rim, aam, aom, pcm,
                 fma, act, af, ret};

   function automatic logic [38:0] expv(
      input logic [3:0] e_rd, input logic [3:0] e_rs, input logic [3:0] e_rt,
      input logic [2:0] e_nzp, input logic [7:0] e_imm,
      input logic e_rw, input logic e_mr, input logic e_mw, input logic e_nw,
      input logic [2:0] e_rim, input logic [1:0] e_aam, input logic e_aom,
      input logic e_pcm, input logic e_fma, input logic e_act,
      input logic [1:0] e_af, input logic e_ret);
      return {e_rd, e_rs, e_rt, e_nzp, e_imm, e_rw, e_mr, e_mw, e_nw, e_rim,
              e_aam, e_aom, e_pcm, e_fma, e_act, e_af, e_ret};
   endfunction

   // Apply inputs away from the active edge, then sample 1 time unit after it.
   task automatic step(input logic r, input logic [2:0] st, input logic [15:0] ins);
      @(negedge clk);
      reset       = r;
      core_state  = st;
      instruction = ins;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [38:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   initial begin
      reset = 1'b1; core_state = 3'd2; instruction = 16'hFFFF;

      step(1'b1, 3'd2, 16'hFFFF);
      step(1'b1, 3'd2, 16'hFFFF);
      check("reset", '0);

      step(1'b0, 3'd2, 16'h3123);
      check("add", expv(4'h1,4'h2,4'h3,3'b000,8'h23, 1,0,0,0, 3'd0,2'd0,0,0,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'h7450);
      check("ldr", expv(4'h4,4'h5,4'h0,3'b010,8'h50, 1,1,0,0, 3'd1,2'd0,0,0,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'h8045);
      check("str", expv(4'h0,4'h4,4'h5,3'b000,8'h45, 0,0,1,0, 3'd0,2'd0,0,0,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'h1A07);
      check("brnzp", expv(4'hA,4'h0,4'h7,3'b101,8'h07, 0,0,0,0, 3'd0,2'd0,0,1,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'h2012);
      check("cmp", expv(4'h0,4'h1,4'h2,3'b000,8'h12, 0,0,0,1, 3'd0,2'd0,1,0,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'h95AB);
      check("const", expv(4'h5,4'hA,4'hB,3'b010,8'hAB, 1,0,0,0, 3'd2,2'd0,0,0,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'hA456);
      check("fma", expv(4'h4,4'h5,4'h6,3'b010,8'h56, 1,0,0,0, 3'd3,2'd0,0,0,1,0,2'd0,0));

      step(1'b0, 3'd2, 16'hB312);
      check("act_sigmoid", expv(4'h3,4'h1,4'h2,3'b001,8'h12, 1,0,0,0, 3'd4,2'd0,0,0,0,1,2'd2,0));

      step(1'b0, 3'd2, 16'hB0E7);
      check("act_tanh", expv(4'h0,4'hE,4'h7,3'b000,8'hE7, 1,0,0,0, 3'd4,2'd0,0,0,0,1,2'd3,0));

      step(1'b0, 3'd2, 16'hF000);
      check("ret", expv(4'h0,4'h0,4'h0,3'b000,8'h00, 0,0,0,0, 3'd0,2'd0,0,0,0,0,2'd0,1));

      step(1'b0, 3'd2, 16'hC123);
      check("reserved_c", expv(4'h1,4'h2,4'h3,3'b000,8'h23, 0,0,0,0, 3'd0,2'd0,0,0,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'h4ABC);
      check("sub", expv(4'hA,4'hB,4'hC,3'b101,8'hBC, 1,0,0,0, 3'd0,2'd1,0,0,0,0,2'd0,0));

      // Low bits 11 must not reach act_func outside ACT.
      step(1'b0, 3'd2, 16'h6FFF);
      check("div", expv(4'hF,4'hF,4'hF,3'b111,8'hFF, 1,0,0,0, 3'd0,2'd3,0,0,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'hEFFF);
      check("reserved_e", expv(4'hF,4'hF,4'hF,3'b111,8'hFF, 0,0,0,0, 3'd0,2'd0,0,0,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'h0BCD);
      check("nop", expv(4'hB,4'hC,4'hD,3'b101,8'hCD, 0,0,0,0, 3'd0,2'd0,0,0,0,0,2'd0,0));

      step(1'b0, 3'd2, 16'h5321);
      check("mul", expv(4'h3,4'h2,4'h1,3'b001,8'h21, 1,0,0,0, 3'd0,2'd2,0,0,0,0,2'd0,0));

      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'd5, 16'hF000);
         check("hold_execute", expv(4'h3,4'h2,4'h1,3'b001,8'h21, 1,0,0,0, 3'd0,2'd2,0,0,0,0,2'd0,0));
      end

      step(1'b0, 3'd6, 16'hA456);
      check("hold_update", expv(4'h3,4'h2,4'h1,3'b001,8'h21, 1,0,0,0, 3'd0,2'd2,0,0,0,0,2'd0,0));

      step(1'b0, 3'd1, 16'h7450);
      check("hold_fetch", expv(4'h3,4'h2,4'h1,3'b001,8'h21, 1,0,0,0, 3'd0,2'd2,0,0,0,0,2'd0,0));

      step(1'b1, 3'd5, 16'hF000);
      check("reset_mid", '0);

      step(1'b0, 3'd7, 16'h3123);
      check("hold_after_reset", '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
